// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 board-state logic.
package game2048_pkg;

  localparam int BOARD_W   = 64;
  localparam int TILE_W    = 4;
  localparam int NUM_CELLS = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    SCAN,
    PLACE,
    CHECK
  } state_t;

  // Cell n (row*4+col) lives in bits [63-4n -: 4]; row 0 col 0 sits in the MSBs.
  function automatic logic [5:0] cell_msb(input logic [3:0] idx);
    return 6'(BOARD_W - 1 - TILE_W * int'(idx));
  endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Handshake/status bundle between the game controller and tile_spawner.
interface tile_spawner_if;
  import game2048_pkg::*;

  logic               start;
  logic               move_valid;
  logic [BOARD_W-1:0] move_board;
  logic [BOARD_W-1:0] cur_board;
  logic               busy;
  logic               spawned;
  logic               win;
  logic               game_over;

  modport master (
    output start, move_valid, move_board,
    input  cur_board, busy, spawned, win, game_over
  );

  modport slave (
    input  start, move_valid, move_board,
    output cur_board, busy, spawned, win, game_over
  );
endinterface

// File: rtl/tile_spawner_lfsr16.sv
// 16-bit Galois LFSR, right-shifting, free-running; reloads seed on rst.
module lfsr16
  import game2048_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic [15:0] q_next;

  always_comb begin
    q_next = {1'b0, q_reg[15:1]} ^ (q_reg[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= seed;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/tile_spawner.sv
// 2048 board-state owner: commits moves, spawns tiles, reports win/game-over.
// Optional feature macro: SPAWN_FOUR_EN (occasionally spawn a 4 instead of a 2).
module tile_spawner
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WIN_LEVEL = 11
) (
  input  logic           clk,
  input  logic           rst,
  tile_spawner_if.slave  bus
);

  localparam logic [TILE_W-1:0] WIN_NIB = 4'(WIN_LEVEL);

  state_t             state_reg;
  logic [BOARD_W-1:0] cand_reg;
  logic [BOARD_W-1:0] cur_board_reg;
  logic [3:0]         ptr_reg;
  logic [3:0]         cnt_reg;
  logic               scan_first_reg;
  logic [1:0]         spawns_left_reg;
  logic               busy_reg;
  logic               spawned_reg;
  logic               win_reg;
  logic               game_over_reg;

  logic [15:0]        lfsr_q;
  logic               lfsr_unused;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // The first SCAN cycle tests the LFSR-chosen cell directly, so k counts from 1.
  logic [3:0]        scan_ptr;
  logic [3:0]        scan_cnt;
  logic [TILE_W-1:0] scan_cell;
  logic [TILE_W-1:0] new_tile;
  logic [BOARD_W-1:0] placed_board;

  always_comb begin
    scan_ptr  = scan_first_reg ? lfsr_q[3:0] : ptr_reg;
    scan_cnt  = scan_first_reg ? 4'd0 : cnt_reg;
    scan_cell = cand_reg[cell_msb(scan_ptr) -: TILE_W];
  end

`ifdef SPAWN_FOUR_EN
  assign new_tile    = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
  assign lfsr_unused = ^lfsr_q[15:8];
`else
  assign new_tile    = 4'd1;
  assign lfsr_unused = ^lfsr_q[15:4];
`endif

  always_comb begin
    placed_board = cand_reg;
    placed_board[cell_msb(ptr_reg) -: TILE_W] = new_tile;
  end

  // Per-cell status of the committed board for the CHECK state.
  logic [TILE_W-1:0]    nib [NUM_CELLS];
  logic [NUM_CELLS-1:0] empty_vec;
  logic [NUM_CELLS-1:0] win_vec;
  logic [NUM_CELLS-1:0] pair_h;
  logic [NUM_CELLS-1:0] pair_v;

  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    assign nib[gi]       = cur_board_reg[BOARD_W-1-TILE_W*gi -: TILE_W];
    assign empty_vec[gi] = (nib[gi] == '0);
    assign win_vec[gi]   = (nib[gi] >= WIN_NIB);

    if (gi % 4 != 3) begin : g_h
      assign pair_h[gi] = !empty_vec[gi] && (nib[gi] == nib[gi+1]);
    end else begin : g_nh
      assign pair_h[gi] = 1'b0;
    end

    if (gi < NUM_CELLS - 4) begin : g_v
      assign pair_v[gi] = !empty_vec[gi] && (nib[gi] == nib[gi+4]);
    end else begin : g_nv
      assign pair_v[gi] = 1'b0;
    end
  end

  logic game_over_now;
  logic win_now;

  assign game_over_now = ~|empty_vec && ~|pair_h && ~|pair_v;
  assign win_now       = |win_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cand_reg        <= '0;
      cur_board_reg   <= '0;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      scan_first_reg  <= 1'b0;
      spawns_left_reg <= '0;
      busy_reg        <= 1'b0;
      spawned_reg     <= 1'b0;
      win_reg         <= 1'b0;
      game_over_reg   <= 1'b0;
    end else begin
      spawned_reg <= 1'b0;
      if (bus.start) begin
        // start wins over move_valid and aborts anything in flight.
        cand_reg        <= '0;
        cur_board_reg   <= '0;
        win_reg         <= 1'b0;
        game_over_reg   <= 1'b0;
        spawns_left_reg <= 2'd2;
        scan_first_reg  <= 1'b1;
        busy_reg        <= 1'b1;
        state_reg       <= SCAN;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (bus.move_valid) begin
              cand_reg  <= bus.move_board;
              busy_reg  <= 1'b1;
              state_reg <= CMP;
            end
          end
          CMP: begin
            if (cand_reg == cur_board_reg) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              spawns_left_reg <= 2'd1;
              scan_first_reg  <= 1'b1;
              state_reg       <= SCAN;
            end
          end
          SCAN: begin
            scan_first_reg <= 1'b0;
            if (scan_cell == '0) begin
              ptr_reg   <= scan_ptr;
              state_reg <= PLACE;
            end else if (scan_cnt == 4'd15) begin
              state_reg <= CHECK;
            end else begin
              ptr_reg <= scan_ptr + 4'd1;
              cnt_reg <= scan_cnt + 4'd1;
            end
          end
          PLACE: begin
            cand_reg        <= placed_board;
            spawned_reg     <= 1'b1;
            spawns_left_reg <= spawns_left_reg - 2'd1;
            if (spawns_left_reg == 2'd1) begin
              cur_board_reg <= placed_board;
              state_reg     <= CHECK;
            end else begin
              scan_first_reg <= 1'b1;
              state_reg      <= SCAN;
            end
          end
          CHECK: begin
            win_reg       <= win_reg | win_now;
            game_over_reg <= game_over_now;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
          default: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cur_board = cur_board_reg;
  assign bus.busy      = busy_reg;
  assign bus.spawned   = spawned_reg;
  assign bus.win       = win_reg;
  assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed self-checking bench for tile_spawner (default build).
module tb_tile_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_spawner_if ts ();

  tile_spawner #(
    .LFSR_SEED (SEED),
    .WIN_LEVEL (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ts)
  );

  // Reference LFSR, used only to predict where the scan starts.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_nz(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[63-4*i -: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic int count_val(input logic [63:0] b, input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[63-4*i -: 4] == v) n++;
    return n;
  endfunction

  // Drives one request at the current negedge and follows it until busy drops.
  task automatic do_op(input string name, input logic st, input logic mv, input logic [63:0] mb,
                       input int scan_at, input logic inject,
                       output int busy_cyc, output int spawns, output logic [3:0] p,
                       output logic [63:0] first_cur, output logic first_win,
                       output logic [63:0] last_cur, output logic last_go);
    ts.start      = st;
    ts.move_valid = mv;
    ts.move_board = mb;
    @(negedge clk);
    ts.start      = 1'b0;
    ts.move_valid = 1'b0;
    busy_cyc  = 0;
    spawns    = 0;
    p         = 4'd0;
    first_cur = ts.cur_board;
    first_win = ts.win;
    last_cur  = '0;
    last_go   = 1'b0;
    for (int i = 0; i < 40 && ts.busy; i++) begin
      busy_cyc++;
      if (busy_cyc == scan_at) p = m_lfsr[3:0];
      if (ts.spawned) spawns++;
      last_cur = ts.cur_board;
      last_go  = ts.game_over;
      if (inject && busy_cyc == 2) begin
        ts.move_valid = 1'b1;
        ts.move_board = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      @(negedge clk);
      ts.move_valid = 1'b0;
    end
    check({name, "_done"}, 64'(ts.busy), 64'd0);
    $display("[TB] %s: busy=%0d spawns=%0d p=%0d board=%h win=%0b go=%0b",
             name, busy_cyc, spawns, p, ts.cur_board, ts.win, ts.game_over);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          bc, sp;
  logic [3:0]  p;
  logic [63:0] fc, lc;
  logic        fw, lg;

  initial begin
    ts.start      = 1'b0;
    ts.move_valid = 1'b0;
    ts.move_board = '0;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_board", ts.cur_board, 64'd0);
    check("rst_busy", 64'(ts.busy), 64'd0);
    check("rst_win", 64'(ts.win), 64'd0);
    check("rst_go", 64'(ts.game_over), 64'd0);
    check("rst_spawned", 64'(ts.spawned), 64'd0);
    rst = 1'b0;

    // New game; simultaneous move_valid must lose to start
    do_op("start", 1'b1, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 1, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("start_spawns", 64'(sp), 64'd2);
    check("start_nz", 64'(count_nz(ts.cur_board)), 64'd2);
    check("start_ones", 64'(count_val(ts.cur_board, 4'd1)), 64'd2);
    check("start_win", 64'(ts.win), 64'd0);
    check("start_go", 64'(ts.game_over), 64'd0);

    // Single empty target -> tile in cell 15, latency 3+k, then game over
    do_op("single", 1'b0, 1'b1, 64'h1212_2121_1212_2120, 2, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("single_busy", 64'(bc), 64'(3 + 16 - int'(p)));
    check("single_spawns", 64'(sp), 64'd1);
    check("single_board", ts.cur_board, 64'h1212_2121_1212_2121);
    check("single_commit_in_check", lc, 64'h1212_2121_1212_2121);
    check("single_go_late", 64'(lg), 64'd0);
    check("single_go", 64'(ts.game_over), 64'd1);
    check("single_win", 64'(ts.win), 64'd0);

    // Unchanged move: one busy cycle, no spawn
    do_op("same", 1'b0, 1'b1, 64'h1212_2121_1212_2121, 2, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("same_busy", 64'(bc), 64'd1);
    check("same_spawns", 64'(sp), 64'd0);
    check("same_board", ts.cur_board, 64'h1212_2121_1212_2121);
    check("same_go", 64'(ts.game_over), 64'd1);

    // Winning tile
    do_op("win", 1'b0, 1'b1, 64'hB000_0000_0000_0000, 2, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("win_busy", 64'(bc), 64'((p == 4'd0) ? 5 : 4));
    check("win_spawns", 64'(sp), 64'd1);
    check("win_cell0", 64'(ts.cur_board[63:60]), 64'hB);
    check("win_nz", 64'(count_nz(ts.cur_board)), 64'd2);
    check("win_flag", 64'(ts.win), 64'd1);
    check("win_go", 64'(ts.game_over), 64'd0);

    // win is sticky through a later move without the tile
    do_op("sticky", 1'b0, 1'b1, 64'h1000_0000_0000_0000, 2, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("sticky_spawns", 64'(sp), 64'd1);
    check("sticky_cell0", 64'(ts.cur_board[63:60]), 64'h1);
    check("sticky_nz", 64'(count_nz(ts.cur_board)), 64'd2);
    check("sticky_win", 64'(ts.win), 64'd1);

    // Abort: start during SCAN, with a move_valid injected while busy
    ts.move_valid = 1'b1;
    ts.move_board = 64'h0100_0000_0000_0000;
    @(negedge clk);
    ts.move_valid = 1'b0;
    @(negedge clk);
    check("abort_in_scan_busy", 64'(ts.busy), 64'd1);
    do_op("abort", 1'b1, 1'b0, 64'd0, 1, 1'b1, bc, sp, p, fc, fw, lc, lg);
    check("abort_cleared", fc, 64'd0);
    check("abort_win_cleared", 64'(fw), 64'd0);
    check("abort_spawns", 64'(sp), 64'd2);
    check("abort_nz", 64'(count_nz(ts.cur_board)), 64'd2);
    check("abort_ones", 64'(count_val(ts.cur_board, 4'd1)), 64'd2);
    check("abort_win", 64'(ts.win), 64'd0);
    check("abort_go", 64'(ts.game_over), 64'd0);

    // Reset in the middle of an operation
    ts.move_valid = 1'b1;
    ts.move_board = 64'h2000_0000_0000_0000;
    @(negedge clk);
    ts.move_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_board", ts.cur_board, 64'd0);
    check("midrst_busy", 64'(ts.busy), 64'd0);
    check("midrst_spawned", 64'(ts.spawned), 64'd0);
    rst = 1'b0;

    do_op("restart", 1'b1, 1'b0, 64'd0, 1, 1'b0, bc, sp, p, fc, fw, lc, lg);
    check("restart_spawns", 64'(sp), 64'd2);
    check("restart_nz", 64'(count_nz(ts.cur_board)), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
